// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared state type and width limits for the sequential multiplier
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int WIDTH_MAX = 32;
    localparam int WIDTH_MIN = 1;

endpackage

// File: rtl/seq_multiplier_if.sv
// rtl/seq_multiplier_if.sv - start/busy/done operand and product bundle
interface seq_multiplier_if #(
    parameter int WIDTH = 8
);
    import seq_mult_pkg::*;

    logic               start;
    logic [WIDTH-1:0]   num1;
    logic [WIDTH-1:0]   num2;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] prod;

    modport master (
        output start, num1, num2,
        input  busy, done, prod
    );

    modport slave (
        input  start, num1, num2,
        output busy, done, prod
    );

endinterface

// File: rtl/add_nbit.sv
// rtl/add_nbit.sv - WIDTH-bit ripple adder with carry out from half/full adder cells
module add_nbit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:1] c;

    // No carry in, so the LSB only needs a half adder
    half_adder u_ha (
        .a  (a[0]),
        .b  (b[0]),
        .s  (sum[0]),
        .co (c[1])
    );

    for (genvar i = 1; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign cout = c[WIDTH];

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - single-bit half adder cell
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic co
);

    assign s  = a ^ b;
    assign co = a & b;

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - shift-and-add unsigned multiplier, optional SEQ_MULT_EARLY_TERM_EN
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    seq_multiplier_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("seq_multiplier: WIDTH outside supported range");
    end

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               carry;
    logic [2*WIDTH:0]   acc_wide;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] acc_fin;
    logic               last;

    assign addend = mplier[0] ? mcand : '0;

    add_nbit #(
        .WIDTH (WIDTH)
    ) u_add (
        .a    (acc[2*WIDTH-1:WIDTH]),
        .b    (addend),
        .sum  (sum),
        .cout (carry)
    );

    // Carry joins the upper half before the right shift, so nothing is lost
    assign acc_wide = {carry, sum, acc[WIDTH-1:0]};
    assign acc_step = (2*WIDTH)'(acc_wide >> 1);

`ifdef SEQ_MULT_EARLY_TERM_EN
    logic [WIDTH-1:0] mplier_nxt;

    assign mplier_nxt = mplier >> 1;
    assign last       = (cnt == LAST) || (mplier_nxt == '0);
    // Remaining multiplier bits are all zero: the outstanding shifts collapse into one
    assign acc_fin    = acc_step >> (LAST - cnt);
`else
    assign last    = (cnt == LAST);
    assign acc_fin = acc_step;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.prod <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        state    <= RUN;
                        bus.busy <= 1'b1;
                        mcand    <= bus.num1;
                        mplier   <= bus.num2;
                        acc      <= '0;
                        cnt      <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc    <= acc_step;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (last) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.prod <= acc_fin;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - randomized and directed checks of seq_multiplier against a latency/product model
module tb_seq_multiplier;

    localparam int W = 8;
`ifdef SEQ_MULT_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    // Model: cycles of busy left, done flag, held product, product in flight
    int             m_rem  = 0;
    logic           m_done = 1'b0;
    logic [2*W-1:0] m_prod = '0;
    logic [2*W-1:0] m_pend = '0;

    always #5 clk = ~clk;

    seq_multiplier_if #(.WIDTH(W))  bus   ();
    seq_multiplier_if #(.WIDTH(1))  bus1  ();
    seq_multiplier_if #(.WIDTH(32)) bus32 ();

    seq_multiplier #(.WIDTH(W))  dut   (.clk(clk), .rst(rst), .bus(bus));
    seq_multiplier #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
    seq_multiplier #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

    function automatic int lat8(input logic [W-1:0] b);
        int h;
        h = 0;
        if (!EARLY) return W + 1;
        for (int i = 0; i < W; i++) if (b[i]) h = i;
        return h + 2;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_rem  = 0;
        m_done = 1'b0;
        m_prod = '0;
    endtask

    // One clock: compare outputs mid-cycle, advance the model on the edge, return just after it
    task automatic tick();
        @(negedge clk);
        if (rst) model_reset();
        chk("cycle busy/done/prod", 64'({bus.busy, bus.done, bus.prod}),
            64'({m_rem > 0, m_done, m_prod}));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_done = 1'b1;
                    m_prod = m_pend;
                end
            end else if (bus.start) begin
                m_pend = 16'(bus.num1) * 16'(bus.num2);
                m_rem  = lat8(bus.num2) - 1;
            end
        end
        #2;
    endtask

    task automatic op8(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] want, input int want_lat);
        int n;
        bus.start = 1'b1;
        bus.num1  = a;
        bus.num2  = b;
        tick();
        bus.start = 1'b0;
        bus.num1  = 8'($urandom);
        bus.num2  = 8'($urandom);
        n = 1;
        while (bus.done !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        chk("op latency", 64'(n), 64'(want_lat));
        chk("op prod", 64'(bus.prod), 64'(want));
        tick();
    endtask

    initial begin
        int n;
        int m;
        int seen;

        bus.start = 1'b0;   bus.num1 = '0;   bus.num2 = '0;
        bus1.start = 1'b0;  bus1.num1 = '0;  bus1.num2 = '0;
        bus32.start = 1'b0; bus32.num1 = '0; bus32.num2 = '0;

        tick();
        tick();
        chk("reset state", 64'({bus.busy, bus.done, bus.prod}), 64'(0));
        rst = 1'b0;
        tick();

        op8(8'd13,  8'd11,  16'd143,   EARLY ? 5 : 9);
        op8(8'hFF,  8'hFF,  16'hFE01,  9);
        op8(8'h00,  8'hA5,  16'd0,     9);
        op8(8'hA5,  8'h00,  16'd0,     EARLY ? 2 : 9);
        op8(8'd200, 8'd3,   16'd600,   EARLY ? 3 : 9);
        op8(8'd1,   8'd128, 16'd128,   9);

        // Back-to-back with start held high across the first done
        bus.start = 1'b1; bus.num1 = 8'd3; bus.num2 = 8'd5;
        tick();
        bus.num1 = 8'd7; bus.num2 = 8'd9;
        n = 1;
        while (bus.done !== 1'b1 && n < 64) begin tick(); n++; end
        chk("b2b first latency", 64'(n), 64'(EARLY ? 4 : 9));
        chk("b2b first prod", 64'(bus.prod), 64'(15));
        tick();
        bus.start = 1'b0;
        m = 1;
        bus.start = 1'b1; bus.num1 = 8'd1; bus.num2 = 8'd1;
        tick();
        m++;
        bus.start = 1'b0;
        chk("prod held during run", 64'(bus.prod), 64'(15));
        while (bus.done !== 1'b1 && m < 64) begin tick(); m++; end
        chk("b2b done spacing", 64'(m), 64'(EARLY ? 5 : 9));
        chk("b2b second prod", 64'(bus.prod), 64'(63));
        tick();

        // Reset in the fourth busy cycle of 200x200
        bus.start = 1'b1; bus.num1 = 8'd200; bus.num2 = 8'd200;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        chk("abort busy/prod", 64'({bus.busy, bus.done, bus.prod}), 64'(0));
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done === 1'b1) seen++;
        end
        chk("no done after abort", 64'(seen), 64'(0));
        op8(8'd2, 8'd2, 16'd4, EARLY ? 3 : 9);

        // Narrowest and widest builds
        bus1.start = 1'b1; bus1.num1 = 1'b1; bus1.num2 = 1'b1;
        tick();
        bus1.start = 1'b0;
        n = 1;
        while (bus1.done !== 1'b1 && n < 64) begin tick(); n++; end
        chk("w1 latency", 64'(n), 64'(2));
        chk("w1 prod", 64'(bus1.prod), 64'(2'b01));
        tick();

        bus32.start = 1'b1; bus32.num1 = 32'hFFFF_FFFF; bus32.num2 = 32'h2;
        tick();
        bus32.start = 1'b0;
        bus32.num1 = 32'h0;
        n = 1;
        while (bus32.done !== 1'b1 && n < 100) begin tick(); n++; end
        chk("w32 latency", 64'(n), 64'(EARLY ? 3 : 33));
        chk("w32 prod", 64'(bus32.prod), 64'h1_FFFF_FFFE);
        tick();

        // Random start/operand/reset traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            bus.start = ($urandom_range(0, 3) == 0);
            bus.num1  = 8'($urandom);
            bus.num2  = 8'($urandom) >> $urandom_range(0, 8);
            rst       = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
